// File: rtl/bs_seq_pkg.sv
// Shared types and constants for the backscatter frame sequencer.
package bs_seq_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPre    = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StGap    = 3'd4
  } state_e;

  localparam logic [7:0] PREAMBLE_DEFAULT = 8'b1010_1011;

  // Tone select encoding on the FSK mux pin.
  localparam logic TONE_A = 1'b0;
  localparam logic TONE_B = 1'b1;

  function automatic logic tone_of(input logic sym);
    return sym ? TONE_B : TONE_A;
  endfunction

endpackage

// File: rtl/bs_bit_timer.sv
// Cycle counter with clear and a runtime terminal count; bit_tick marks the last cycle.
module bs_bit_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_2,
  input  logic             rst_n_in,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             bit_tick
);

  logic [CNT_W-1:0] cnt_q;

  assign bit_tick = (cnt_q == limit);

  // Count up, wrapping to 0 on terminal count or when cleared.
  always_ff @(posedge clk_2 or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
    end else if (clear || bit_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bs_frame_sequencer.sv
// Backscatter frame sequencer: preamble, MSB-first payload, even parity, then gap.
module bs_frame_sequencer
  import bs_seq_pkg::*;
#(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       PRE_W      = 8,
  parameter logic [PRE_W-1:0]  PREAMBLE   = PREAMBLE_DEFAULT,
  parameter int unsigned       BIT_CYCLES = 4,
  parameter int unsigned       GAP_CYCLES = 16
) (
  input  logic              clk_2,
  input  logic              rst_n_in,
  input  logic              start_valid,
  input  logic [DATA_W-1:0] start_data,
  output logic              start_ready,
  input  logic              abort,
  output logic              sw_en,
  output logic              fsk_sel,
  output logic              tx_active,
  output logic              frame_done
);

  localparam int unsigned IDX_MAX = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int unsigned IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
  localparam int unsigned CYC_MAX = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  localparam logic [CNT_W-1:0] BIT_LIMIT = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PRE_W - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic [DATA_W-1:0] shreg_q;
  logic              parity_q;

  logic              bit_tick;
  logic              timer_clear;
  logic [CNT_W-1:0]  timer_limit;
  logic              pre_next;
  logic [DATA_W-1:0] shreg_shift;

  assign start_ready = (state_q == StIdle);
  // Abort clears the counter on the same edge that forces IDLE.
  assign timer_clear = (state_q == StIdle) || abort;
  assign timer_limit = (state_q == StGap) ? GAP_LIMIT : BIT_LIMIT;
  assign shreg_shift = shreg_q << 1;

  bs_bit_timer #(
    .CNT_W (CNT_W)
  ) u_bit_timer (
    .clk_2    (clk_2),
    .rst_n_in (rst_n_in),
    .clear    (timer_clear),
    .limit    (timer_limit),
    .bit_tick (bit_tick)
  );

  // Preamble bit that follows the one at bit_idx_q (MSB first).
  always_comb begin
    pre_next = 1'b0;
    for (int i = 0; i < int'(PRE_W) - 1; i++) begin
      if (int'(bit_idx_q) == i) pre_next = PREAMBLE[PRE_W-2-i];
    end
  end

  // Frame FSM with shift register, parity and registered pin outputs.
  always_ff @(posedge clk_2 or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StIdle;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      sw_en      <= 1'b0;
      fsk_sel    <= TONE_A;
      tx_active  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state_q != StIdle && abort) begin
        state_q   <= StIdle;
        bit_idx_q <= '0;
        sw_en     <= 1'b0;
        fsk_sel   <= TONE_A;
        tx_active <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_valid) begin
              state_q   <= StPre;
              bit_idx_q <= '0;
              shreg_q   <= start_data;
              parity_q  <= ^start_data;
              sw_en     <= 1'b1;
              fsk_sel   <= tone_of(PREAMBLE[PRE_W-1]);
              tx_active <= 1'b1;
            end
          end
          StPre: begin
            if (bit_tick) begin
              if (bit_idx_q == PRE_LAST) begin
                state_q   <= StData;
                bit_idx_q <= '0;
                fsk_sel   <= tone_of(shreg_q[DATA_W-1]);
              end else begin
                bit_idx_q <= bit_idx_q + IDX_W'(1);
                fsk_sel   <= tone_of(pre_next);
              end
            end
          end
          StData: begin
            if (bit_tick) begin
              if (bit_idx_q == DATA_LAST) begin
                state_q   <= StParity;
                bit_idx_q <= '0;
                fsk_sel   <= tone_of(parity_q);
              end else begin
                bit_idx_q <= bit_idx_q + IDX_W'(1);
                shreg_q   <= shreg_shift;
                fsk_sel   <= tone_of(shreg_shift[DATA_W-1]);
              end
            end
          end
          StParity: begin
            if (bit_tick) begin
              state_q <= StGap;
              sw_en   <= 1'b0;
              fsk_sel <= TONE_A;
            end
          end
          StGap: begin
            if (bit_tick) begin
              state_q    <= StIdle;
              tx_active  <= 1'b0;
              frame_done <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/bs_frame_sequencer.md
# bs_frame_sequencer

Sequences one backscatter frame per request in the `clk_2` domain: preamble, MSB-first payload, even-parity bit, then an inter-frame gap. It drives the antenna switch enable and the FSK tone select that picks which CW subcarrier is backscattered. It sits between the frame source (firmware or test logic) and the RF switch and tone-mux pins, and is the only block that controls them.

## Interface
Parameters:
- `DATA_W`, 16: payload bits per frame.
- `PRE_W`, 8: preamble length in bits.
- `PREAMBLE`, 8'b1010_1011: preamble pattern, sent MSB first.
- `BIT_CYCLES`, 4: `clk_2` cycles per symbol. Must be ≥1.
- `GAP_CYCLES`, 16: idle cycles after each frame. Must be ≥1.

Ports:
- `clk_2`, in, 1: sequencer clock.
- `rst_n_in`, in, 1: reset, asynchronous, active-low.
- `start_valid`, in, 1: frame request.
- `start_data`, in, DATA_W: payload. Sampled on accept.
- `start_ready`, out, 1: high only in IDLE.
- `abort`, in, 1: synchronous frame abort.
- `sw_en`, out, 1: antenna switch enable. High during PRE, DATA and PARITY.
- `fsk_sel`, out, 1: current symbol value. 0 selects tone A, 1 selects tone B.
- `tx_active`, out, 1: high in any state except IDLE.
- `frame_done`, out, 1: one-cycle pulse when a frame completes normally.

## Operation
- States, in order: IDLE, PRE, DATA, PARITY, GAP. The state encoding and `PREAMBLE` default live in the package.
- Accept occurs on `start_valid && start_ready` at a clock edge.
  - On accept: latch `start_data` into the shift register and compute parity as the XOR of all data bits.
  - Next state is PRE with bit index 0 and cycle counter 0.
- Symbol timing:
  - Each symbol is held exactly `BIT_CYCLES` cycles.
  - `bit_tick` asserts on the last cycle of each symbol (cycle count = `BIT_CYCLES`−1).
  - On `bit_tick` the block advances to the next bit or state.
- PRE sends `PREAMBLE[PRE_W-1]` down to `[0]`.
- DATA sends `data[DATA_W-1]` down to `[0]`.
- PARITY sends the even-parity bit for one symbol.
- GAP holds `sw_en=0` and `fsk_sel=0` for `GAP_CYCLES` cycles, then returns to IDLE.
  - `frame_done` is asserted in the first IDLE cycle after GAP.
- `abort` sampled high in any non-IDLE state forces IDLE on the next edge.
  - Counters clear, `sw_en=0`, and no `frame_done` is produced.
  - `abort` has priority over `bit_tick` and over GAP completion.
  - `abort` in IDLE is ignored. If `abort` and `start_valid` are both high in IDLE, the frame is accepted.
- `start_valid` outside IDLE is ignored. There is no queueing; the requester must hold `start_valid` until it is accepted.
- Widths:
  - Bit index: `$clog2(max(PRE_W,DATA_W))`.
  - Cycle counter: `$clog2(max(BIT_CYCLES,GAP_CYCLES))`, minimum 1 bit.
  - Both counters wrap to 0 on every state change; no overflow is possible.

## Timing
- Reset values: state IDLE, `sw_en=0`, `fsk_sel=0`, `tx_active=0`, `frame_done=0`, counters 0.
  - `start_ready=1` is driven from state, including while reset is asserted.
- Reset mid-frame drops `sw_en` and `fsk_sel` asynchronously. No `frame_done` is produced.
- `sw_en`, `fsk_sel`, `tx_active` and `frame_done` are registered outputs, free of glitches.
- Latency: with accept at edge 0, `sw_en=1` and `fsk_sel=PREAMBLE[PRE_W-1]` are visible in cycle 1.
- Active window: cycles 1 to (PRE_W+DATA_W+1)·BIT_CYCLES.
- Gap: the following GAP_CYCLES cycles.
- `frame_done` and `start_ready` rise together in the next cycle.
- Back-to-back frames: the earliest next accept is the `frame_done` cycle.

## Structure
- Package `bs_seq_pkg` holds:
  - the state enum,
  - the `PREAMBLE` default,
  - tone encoding constants `TONE_A=0` and `TONE_B=1`.
- Sub-module `bs_bit_timer` holds:
  - the cycle counter, with load/clear,
  - the terminal-count compare against a runtime limit (`BIT_CYCLES-1` or `GAP_CYCLES-1`),
  - the `bit_tick` output.
- The top level holds the FSM, shift register, parity logic and output registers.

## Test plan
- Reset release, then `start_data=16'hA5C3` with defaults:
  - `fsk_sel` shows 10101011, then 1010010111000011, then parity 0, each symbol 4 cycles wide.
  - `sw_en` is high for cycles 1–100, low for 101–116.
  - `frame_done` pulses at cycle 117.
- `start_data=16'h0001`: parity symbol is 1 (cycles 97–100). `frame_done` at cycle 117.
- `abort` at cycle 50:
  - IDLE from cycle 51, `sw_en=0`, `start_ready=1`.
  - No `frame_done` through cycle 130.
- `start_valid` held high continuously: accepts at cycles 0, 117 and 234; `sw_en` gap is exactly 16 cycles each time.
- `rst_n_in` low mid-DATA: `sw_en`, `fsk_sel` and `tx_active` go to 0 immediately, with no `frame_done`. After release, a new frame starts cleanly.
- With `BIT_CYCLES=1` and `GAP_CYCLES=1`: active window is 25 cycles, gap is 1 cycle, `frame_done` at cycle 27.
